// File: rtl/mem_io_bridge.sv
// mem_io_bridge: processor memory/IO bridge with program RAM, LED register, switch port and program loader
//
// Ports:
//   clk, reset_n                         clock (rising edge), asynchronous active-low reset
//   ADDR, DOUT, WEN                      processor bus: address, write data, write enable
//   DIN                                  registered read data, 1-cycle latency, read-first on collisions
//   Run, proc_reset_n                    processor run request and active-low processor reset
//   ld_valid, ld_ready, ld_data, ld_last program loader stream into RAM
//   reload                               return from RUN to LOAD
//   SW                                   asynchronous switches, 2-FF synchronized
//   LEDR                                 LED register
//   prot_err                             sticky write-protect violation flag
// Address map (top two ADDR bits): 00 RAM, 01 LEDR, 10 SW (read-only), 11 reserved (reads 0).
// Build option MEMIO_WRITE_PROTECT_EN: processor writes to RAM words below PROT_LIMIT are dropped
// and set prot_err; without it every RAM word is writable and prot_err stays 0.
module mem_io_bridge #(
    parameter int DATA_W     = 9,
    parameter int RAM_AW     = 7,
    parameter int PROT_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DOUT,
    input  logic              WEN,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic              proc_reset_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic [DATA_W-1:0] SW,
    output logic [DATA_W-1:0] LEDR,
    output logic              prot_err
);
`ifdef MEMIO_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif
    localparam logic [RAM_AW:0] PROT_LIM = PROT_LIMIT[RAM_AW:0];

    typedef enum logic [1:0] {LOAD, START, RUN} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] ram [2**RAM_AW];
    logic [RAM_AW-1:0] ptr, ram_wa;
    logic [DATA_W-1:0] sw_meta, sw_sync, ram_q, rd_data, ram_wd;
    logic [1:0]        sel;
    logic              access, ld_acc, ld_done, ram_wr, prot_hit, ram_we;

    assign sel      = ADDR[DATA_W-1 -: 2];
    assign access   = state != LOAD;
    assign ld_acc   = ld_valid && state == LOAD;
    // Loading ends on the flagged last word or when the final RAM word is filled; the pointer never wraps.
    assign ld_done  = ld_acc && (ld_last || &ptr);
    assign ram_wr   = access && WEN && sel == 2'b00;
    assign prot_hit = PROT_EN && ram_wr && ({1'b0, ADDR[RAM_AW-1:0]} < PROT_LIM);
    // Loader and processor never write in the same state, so one shared write port suffices.
    assign ram_we   = ld_acc || (ram_wr && !prot_hit);
    assign ram_wa   = ld_acc ? ptr : ADDR[RAM_AW-1:0];
    assign ram_wd   = ld_acc ? ld_data : DOUT;
    assign ram_q    = ram[ADDR[RAM_AW-1:0]];
    assign rd_data  = sel == 2'b00 ? ram_q : sel == 2'b01 ? LEDR : sel == 2'b10 ? sw_sync : '0;

    always_comb begin
        state_nxt    = state;
        ld_ready     = 1'b0;
        proc_reset_n = 1'b1;
        Run          = 1'b0;
        case (state)
            LOAD: begin
                ld_ready     = 1'b1;
                proc_reset_n = 1'b0;
                state_nxt    = ld_done ? START : LOAD;
            end
            START: state_nxt = RUN;
            RUN: begin
                Run       = 1'b1;
                state_nxt = reload ? LOAD : RUN;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LOAD;
            ptr      <= '0;
            DIN      <= '0;
            LEDR     <= '0;
            prot_err <= 1'b0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            state   <= state_nxt;
            sw_meta <= SW;
            sw_sync <= sw_meta;
            ptr     <= ld_done ? '0 : ld_acc ? ptr + 1'b1 : ptr;
            // rd_data samples pre-edge LEDR/RAM, giving read-first behaviour on same-edge writes.
            DIN     <= access ? rd_data : '0;
            if (access && WEN && sel == 2'b01) LEDR <= DOUT;
            if (prot_hit) prot_err <= 1'b1;
        end
    end

    // RAM has no reset: its contents survive reload and are undefined after power-up.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
    end
endmodule
